// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe -- RV32 immediate generator behind a 2-entry skid buffer.
//
// Each accepted instruction word is decoded into a sign-extended immediate,
// a format code and an illegal-opcode flag. The result is registered and
// appears on the output one cycle after the input transfer. Up to two
// decoded results are buffered, so the producer can run back-to-back while
// the consumer stalls for a cycle.
//
// Build option: define IMM_GEN_BJ_EN to decode B (1100011) and J (1101111)
// formats. Without it those opcodes are reported as illegal.
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset (priority over flush/transfers)
//   in_valid     instruction word present
//   in_ready     block accepts a word this cycle (registered)
//   instruction  RV32 instruction word
//   flush        discard every buffered entry; a word offered this cycle is dropped
//   out_valid    result present (registered)
//   out_ready    consumer accepts the result
//   immediate    decoded, sign-extended immediate (DATA_WIDTH bits)
//   imm_fmt      0 R/none, 1 I, 2 S, 3 B, 4 U, 5 J, 7 illegal
//   illegal      opcode not recognised
module imm_gen_pipe #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instruction,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] immediate,
  output logic [2:0]            imm_fmt,
  output logic                  illegal
);

  // One buffered entry: {immediate, imm_fmt, illegal}
  localparam int RW = DATA_WIDTH + 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  // Decode one instruction word into a packed {immediate, fmt, illegal} entry.
  // Every format is first built as a 32-bit value whose bit 31 is ins[31],
  // so a single signed widening produces the DATA_WIDTH sign extension.
  function automatic logic [RW-1:0] decode(input logic [31:0] ins);
    logic [31:0]           v32;
    logic [DATA_WIDTH-1:0] ext;
    logic [2:0]            fmt;
    logic                  ill;
    v32 = 32'd0;
    fmt = 3'd0;
    ill = 1'b0;
    case (ins[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        v32 = {{20{ins[31]}}, ins[31:20]};
        fmt = 3'd1;
      end
      7'b0100011: begin
        v32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        fmt = 3'd2;
      end
`ifdef IMM_GEN_BJ_EN
      7'b1100011: begin
        v32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        fmt = 3'd3;
      end
      7'b1101111: begin
        v32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        fmt = 3'd5;
      end
`endif
      7'b0010111, 7'b0110111: begin
        v32 = {ins[31:12], 12'b0};
        fmt = 3'd4;
      end
      7'b0110011: begin
        // R-type carries no immediate; legal with format 0.
        v32 = 32'd0;
        fmt = 3'd0;
      end
      default: begin
        v32 = 32'd0;
        fmt = 3'd7;
        ill = 1'b1;
      end
    endcase
    ext = DATA_WIDTH'($signed(v32));
    return {ext, fmt, ill};
  endfunction

  state_t        state_r;
  state_t        state_nxt;
  logic          in_ready_r;
  logic          out_valid_r;
  logic [RW-1:0] head_r;   // oldest entry, drives the outputs
  logic [RW-1:0] skid_r;   // second entry, used only in state TWO
  logic [RW-1:0] dec;

  logic in_xfer;
  logic out_xfer;
  logic head_load;
  logic head_from_skid;
  logic skid_load;

  assign dec      = decode(instruction);
  assign in_xfer  = in_valid && in_ready_r;
  assign out_xfer = out_valid_r && out_ready;

  // State register plus the registered handshake flags derived from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      in_ready_r  <= (state_nxt != TWO);
      out_valid_r <= (state_nxt != EMPTY);
    end
  end

  // Next-state logic; flush wins over any transfer in the same cycle
  always_comb begin
    state_nxt = state_r;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_xfer) begin
            state_nxt = ONE;
          end else begin
            state_nxt = EMPTY;
          end
        end
        ONE: begin
          if (in_xfer && !out_xfer) begin
            state_nxt = TWO;
          end else if (!in_xfer && out_xfer) begin
            state_nxt = EMPTY;
          end else begin
            state_nxt = ONE;
          end
        end
        TWO: begin
          if (out_xfer) begin
            state_nxt = ONE;
          end else begin
            state_nxt = TWO;
          end
        end
        default: begin
          state_nxt = EMPTY;
        end
      endcase
    end
  end

  // Datapath load controls for the entry registers
  always_comb begin
    head_load      = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      head_load = 1'b0;
    end else begin
      case (state_r)
        EMPTY: begin
          head_load = in_xfer;
        end
        ONE: begin
          // Simultaneous in/out replaces the head; input alone parks in the skid slot.
          head_load = in_xfer && out_xfer;
          skid_load = in_xfer && !out_xfer;
        end
        TWO: begin
          head_load      = out_xfer;
          head_from_skid = out_xfer;
        end
        default: begin
          head_load = 1'b0;
        end
      endcase
    end
  end

  // Entry registers; the head holds its value while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r <= {RW{1'b0}};
      skid_r <= {RW{1'b0}};
    end else begin
      if (head_load) begin
        head_r <= head_from_skid ? skid_r : dec;
      end
      if (skid_load) begin
        skid_r <= dec;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign immediate = head_r[RW-1:4];
  assign imm_fmt   = head_r[3:1];
  assign illegal   = head_r[0];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe (DATA_WIDTH = 32). Expected entries are
// queued when an input transfer is seen and compared when the DUT emits output.
module tb_imm_gen_pipe;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   instruction = 32'd0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] immediate;
  logic [2:0]    imm_fmt;
  logic          illegal;

  imm_gen_pipe #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .immediate(immediate), .imm_fmt(imm_fmt),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_out  = 0;

  // Entry: {imm[63:0], fmt[2:0], ill}
  logic [67:0] sb[$];
  logic        dir_en  = 1'b0;
  logic [67:0] dir_exp = 68'd0;
  logic [67:0] mon_e;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // Reference decoder written with arithmetic shifts on a sign-extended word
  function automatic logic [67:0] model(input logic [31:0] ins);
    logic signed [63:0] sx;
    logic        [63:0] v;
    logic [2:0]         f;
    logic               il;
    sx = $signed({{32{ins[31]}}, ins});
    v = 64'd0; f = 3'd0; il = 1'b0;
    case (ins[6:0])
      7'h13, 7'h03, 7'h67: begin v = sx >>> 20; f = 3'd1; end
      7'h23: begin v = ((sx >>> 25) << 5) | 64'(ins[11:7]); f = 3'd2; end
`ifdef IMM_GEN_BJ_EN
      7'h63: begin
        v = ((sx >>> 31) << 12) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5) | (64'(ins[11:8]) << 1);
        f = 3'd3;
      end
      7'h6F: begin
        v = ((sx >>> 31) << 20) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11) | (64'(ins[30:21]) << 1);
        f = 3'd5;
      end
`endif
      7'h17, 7'h37: begin v = sx & ~64'hFFF; f = 3'd4; end
      7'h33: begin v = 64'd0; f = 3'd0; end
      default: begin v = 64'd0; f = 3'd7; il = 1'b1; end
    endcase
    return {v, f, il};
  endfunction

  // Scoreboard monitor, sampling on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      check_eq("out_valid_vs_sb", 64'(out_valid), 64'(sb.size() != 0));
      check_eq("in_ready_vs_sb", 64'(in_ready), 64'(sb.size() < 2));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_out", 64'd0, 64'd1);
        end else begin
          mon_e = sb.pop_front();
          n_out++;
          check_eq("imm", 64'(immediate), 64'(mon_e[67:4] & 64'hFFFF_FFFF));
          check_eq("fmt", 64'(imm_fmt), 64'(mon_e[3:1]));
          check_eq("ill", 64'(illegal), 64'(mon_e[0]));
        end
      end else if (out_valid && sb.size() != 0) begin
        mon_e = sb[0];
        check_eq("stall_imm", 64'(immediate), 64'(mon_e[67:4] & 64'hFFFF_FFFF));
        check_eq("stall_fmt", 64'(imm_fmt), 64'(mon_e[3:1]));
      end
      if (in_valid && in_ready && !flush) sb.push_back(dir_en ? dir_exp : model(instruction));
      if (flush) sb.delete();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    logic acc;
    instruction = w;
    in_valid = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 50 && !acc; k++) begin
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!acc) check_eq("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_exp(input logic [31:0] w, input logic [63:0] imm, input logic [2:0] f, input logic il);
    dir_exp = {imm, f, il};
    dir_en = 1'b1;
    send(w);
    dir_en = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 40 && sb.size() != 0; k++) tick();
    tick();
    check_eq("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_idle_reset(input string tag);
    check_eq({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check_eq({tag, "_imm"}, 64'(immediate), 64'd0);
    check_eq({tag, "_fmt"}, 64'(imm_fmt), 64'd0);
    check_eq({tag, "_ill"}, 64'(illegal), 64'd0);
  endtask

  initial begin
    int base;
    logic [6:0]  ops [10];
    logic [31:0] r;
    ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h17, 7'h37, 7'h6F, 7'h33, 7'h7F};

    // Reset state
    tick(); tick();
    check_idle_reset("reset");
    rst = 1'b0;

    // ADDI with one-cycle latency
    out_ready = 1'b1;
    send_exp(32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
    check_eq("addi_latency_valid", 64'(out_valid), 64'd1);
    check_eq("addi_imm_direct", 64'(immediate), 64'hFFFF_FFFF);

    // Directed back-to-back formats
    send_exp(32'hFE112E23, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0);
`ifdef IMM_GEN_BJ_EN
    send_exp(32'hFE000CE3, 64'hFFFF_FFFF_FFFF_FFF8, 3'd3, 1'b0);
    send_exp(32'h0010006F, 64'h0000_0000_0000_0800, 3'd5, 1'b0);
`else
    send_exp(32'hFE000CE3, 64'd0, 3'd7, 1'b1);
    send_exp(32'h0010006F, 64'd0, 3'd7, 1'b1);
`endif
    send_exp(32'h0000007F, 64'd0, 3'd7, 1'b1);
    send_exp(32'h00B50533, 64'd0, 3'd0, 1'b0);
    send_exp(32'h80000537, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0);
    send_exp(32'h12345517, 64'h0000_0000_1234_5000, 3'd4, 1'b0);
    send_exp(32'h7FF00093, 64'h0000_0000_0000_07FF, 3'd1, 1'b0);
    drain();

    // Stall: three words, third held off until release
    base = n_out;
    out_ready = 1'b0;
    send(32'h00100093);
    send(32'h00200113);
    check_eq("full_in_ready", 64'(in_ready), 64'd0);
    instruction = 32'h00300193;
    in_valid = 1'b1;
    tick(); tick(); tick();
    check_eq("full_hold_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    send(32'h00300193);
    drain();
    check_eq("stall_no_loss", 64'(n_out - base), 64'd3);

    // Flush in state TWO with a word offered
    out_ready = 1'b0;
    send(32'h00400213);
    send(32'h00500293);
    instruction = 32'h00600313;
    in_valid = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check_eq("flush2_out_valid", 64'(out_valid), 64'd0);
    check_eq("flush2_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();

    // Flush in state ONE: the offered word must be dropped
    base = n_out;
    out_ready = 1'b0;
    send(32'h00700393);
    instruction = 32'h00800413;
    in_valid = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check_eq("flush1_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check_eq("flush1_nothing_out", 64'(n_out - base), 64'd0);

    // Reset in state ONE
    out_ready = 1'b0;
    send(32'hFFF00093);
    check_eq("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_reset("rst_one");

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      r = $urandom();
      instruction = {r[31:7], ops[$urandom_range(0, 9)]};
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    in_valid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, immediate output width; legal values 32 or 64.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  instruction word present.
REQ-005 SHALL have port in_ready  output  1  block accepts a word this cycle; driven from a register.
REQ-006 SHALL have port instruction  input  32  RV32 instruction word.
REQ-007 SHALL have port flush  input  1  discard all buffered entries.
REQ-008 SHALL have port out_valid  output  1  result present.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port immediate  output  DATA_WIDTH  decoded, sign-extended immediate.
REQ-011 SHALL have port imm_fmt  output  3  format code: 0 R/none, 1 I, 2 S, 3 B, 4 U, 5 J, 7 illegal.
REQ-012 SHALL have port illegal  output  1  opcode not recognised.

Function
REQ-013 SHALL decode on instruction[6:0]: 0010011, 0000011, 1100111 -> I; 0100011 -> S; 1100011 -> B; 0010111, 0110111 -> U; 1101111 -> J; 0110011 -> fmt 0, immediate 0, illegal 0.
REQ-014 SHALL map any other opcode to immediate 0, imm_fmt 7, illegal 1.
REQ-015 SHALL form I {ins[31:20]}, S {ins[31:25],ins[11:7]}, B {ins[31],ins[7],ins[30:25],ins[11:8],0}, U {ins[31:12],12'b0}, J {ins[31],ins[19:12],ins[20],ins[30:21],0}.
REQ-016 SHALL sign-extend every format from ins[31] to DATA_WIDTH, U included when DATA_WIDTH is 64.
REQ-017 SHALL transfer input when in_valid && in_ready, output when out_valid && out_ready.
REQ-018 SHALL register the decoded result; latency from input transfer to out_valid is exactly 1 cycle.
REQ-019 SHALL implement a 2-entry skid buffer with states EMPTY, ONE, TWO; in_ready = (state != TWO), registered.
REQ-020 SHALL transition EMPTY->ONE on input transfer; ONE->TWO on input transfer without output transfer; ONE->EMPTY on output transfer without input transfer; TWO->ONE on output transfer; other cases hold.
REQ-021 SHALL preserve order; the oldest entry drives immediate/imm_fmt/illegal, which hold stable while out_valid && !out_ready.
REQ-022 SHALL sustain one transfer per cycle in state ONE with simultaneous input and output transfers.
REQ-023 SHALL, on flush, go to EMPTY next cycle regardless of transfers; a word presented in the flush cycle is dropped; flush has priority over input transfer.
REQ-024 SHALL not change state on in_valid while in_ready is 0.

Reset
REQ-025 SHALL, with rst high at a clk edge, go to EMPTY: out_valid 0, in_ready 1, immediate 0, imm_fmt 0, illegal 0.
REQ-026 SHALL discard buffered entries when rst asserts mid-operation; rst has priority over flush and transfers.

Configuration
REQ-027 SHALL use macro IMM_GEN_BJ_EN to compile in B and J decoding.
REQ-028 SHALL, with IMM_GEN_BJ_EN defined, decode B and J per REQ-015.
REQ-029 SHALL, without IMM_GEN_BJ_EN, treat 1100011 and 1101111 as illegal (immediate 0, imm_fmt 7, illegal 1); handshake unaffected.

Verification
REQ-030 SHALL cover ADDI 0xFFF00093, out_ready 1 -> next cycle out_valid 1, immediate 0xFFFFFFFF (64-bit 0xFFFFFFFFFFFFFFFF), imm_fmt 1.
REQ-031 SHALL cover SW 0xFE112E23 -> immediate 0xFFFFFFFC, imm_fmt 2; BEQ 0xFE000CE3 -> 0xFFFFFFF8, imm_fmt 3; JAL 0x0010006F -> 0x00000800, imm_fmt 5.
REQ-032 SHALL cover out_ready 0, three back-to-back words -> in_ready 0 after two accepted; release -> outputs in order, third accepted, no loss.
REQ-033 SHALL cover flush in state TWO with in_valid 1 -> next cycle out_valid 0, in_ready 1, flushed-cycle word never emitted.
REQ-034 SHALL cover opcode 0x7F, and 0xFE000CE3 with IMM_GEN_BJ_EN undefined -> immediate 0, imm_fmt 7, illegal 1.
REQ-035 SHALL cover rst asserted in state ONE -> next cycle out_valid 0, in_ready 1, outputs 0.
